// File: rtl/k2_program_loader.sv
// Writable instruction store for the K2 processor: a valid/ready byte stream fills the
// memory while the processor is held in reset, and the fetch port reads it combinationally.
module k2_program_loader #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_done,
    output logic                 load_error,
    output logic [DATA_BITS-1:0] checksum,
    output logic                 cpu_hold,
    input  logic [ADDR_BITS-1:0] ProgramAddress,
    output logic [DATA_BITS-1:0] instruction_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 start_load;
    logic                 beat;

    function automatic logic [DATA_BITS-1:0] wrap_add(input logic [DATA_BITS-1:0] a,
                                                      input logic [DATA_BITS-1:0] b);
        return a + b;
    endfunction

    assign cpu_hold   = (state != S_RUN);
    assign load_ready = (state == S_LOAD);
    assign beat       = load_valid && load_ready;

    // load_start is only honoured outside LOAD, so a repeated request cannot restart a load
    assign start_load = load_start && (state != S_LOAD);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            checksum   <= '0;
            load_error <= 1'b0;
            load_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            load_done <= 1'b0;
            if (start_load) begin
                state      <= S_LOAD;
                wr_ptr     <= '0;
                checksum   <= '0;
                load_error <= 1'b0;
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (beat) begin
                mem[wr_ptr] <= load_data;
                checksum    <= wrap_add(checksum, load_data);
                wr_ptr      <= wr_ptr + 1'b1;
                if (load_last) begin
                    state     <= S_RUN;
                    load_done <= 1'b1;
                end else if (&wr_ptr) begin
                    // Store filled without a last beat: drop back and flag the overflow
                    state      <= S_EMPTY;
                    load_error <= 1'b1;
                end
            end
        end
    end

    // Fetch reads the pre-edge contents when the same entry is being written
    assign instruction_data = mem[ProgramAddress];

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed bench for k2_program_loader: load_done events are checked by a scoreboard
// monitor against queued expectations; static state is compared by the stimulus thread.
module tb_k2_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_done;
    logic       load_error;
    logic [7:0] checksum;
    logic       cpu_hold;
    logic [3:0] ProgramAddress;
    logic [7:0] instruction_data;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] em [16];

    k2_program_loader #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_start       (load_start),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .load_done        (load_done),
        .load_error       (load_error),
        .checksum         (checksum),
        .cpu_hold         (cpu_hold),
        .ProgramAddress   (ProgramAddress),
        .instruction_data (instruction_data)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each load_done pulse must match one queued program completion
    always @(negedge clk) begin
        if (load_done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got load_done=1 expected none (checksum %0h)", checksum);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (checksum !== e || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_event: got checksum=%0h hold=%0b err=%0b expected checksum=%0h hold=0 err=0",
                             checksum, cpu_hold, load_error, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_beat);
        load_start = 1'b1;
        load_valid = with_beat;
        load_data  = 8'hEE;
        load_last  = 1'b0;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input int gap);
        int w;
        load_valid = 1'b0;
        repeat (gap) tick();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        w = 0;
        while (!load_ready && w < 20) begin
            tick();
            w++;
        end
        if (!load_ready) chk("beat_ready_timeout", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            ProgramAddress = i[3:0];
            #1;
            chk($sformatf("%s_mem%0d", tag, i), {24'd0, instruction_data}, {24'd0, em[i]});
        end
        ProgramAddress = 4'd0;
        tick();
    endtask

    task automatic set_em(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) em[i] = fill;
    endtask

    initial begin
        rst_n = 1'b1; load_start = 1'b0; load_valid = 1'b0;
        load_data = 8'h00; load_last = 1'b0; ProgramAddress = 4'd0;
        repeat (2) tick();
        rst_n = 1'b0;

        // Reset state
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_checksum", {24'd0, checksum}, 32'h00);
        chk("rst_error", {31'd0, load_error}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        set_em(8'h00);
        check_mem("rst");

        // Beats while EMPTY are ignored
        load_valid = 1'b1; load_data = 8'h77;
        tick(); tick();
        load_valid = 1'b0;
        chk("empty_ignore_cs", {24'd0, checksum}, 32'h00);

        // Short load
        pulse_start(1'b0);
        chk("start_ready", {31'd0, load_ready}, 32'd1);
        exp_q.push_back(8'h9C);
        beat(8'h12, 1'b0, 0);
        beat(8'h34, 1'b0, 0);
        beat(8'h56, 1'b1, 0);
        chk("short_hold_fall", {31'd0, cpu_hold}, 32'd0);
        chk("short_done", {31'd0, load_done}, 32'd1);
        tick();
        chk("short_done_1cyc", {31'd0, load_done}, 32'd0);
        chk("short_checksum", {24'd0, checksum}, 32'h9C);
        set_em(8'h00); em[0] = 8'h12; em[1] = 8'h34; em[2] = 8'h56;
        check_mem("short");

        // Reload from RUN, beat offered with the start is refused
        pulse_start(1'b1);
        chk("reload_hold", {31'd0, cpu_hold}, 32'd1);
        chk("reload_cs", {24'd0, checksum}, 32'h00);
        set_em(8'h00);
        check_mem("reload");
        exp_q.push_back(8'hA5);
        beat(8'hA5, 1'b1, 0);
        chk("one_hold", {31'd0, cpu_hold}, 32'd0);
        chk("one_cs", {24'd0, checksum}, 32'hA5);
        set_em(8'h00); em[0] = 8'hA5;
        check_mem("one");

        // Stalled load, with a redundant load_start in the middle
        pulse_start(1'b0);
        exp_q.push_back(8'h9C);
        beat(8'h12, 1'b0, 3);
        load_start = 1'b1; tick(); load_start = 1'b0;
        beat(8'h34, 1'b0, 5);
        beat(8'h56, 1'b1, 1);
        repeat (3) tick();
        chk("stall_checksum", {24'd0, checksum}, 32'h9C);
        chk("stall_hold", {31'd0, cpu_hold}, 32'd0);
        set_em(8'h00); em[0] = 8'h12; em[1] = 8'h34; em[2] = 8'h56;
        check_mem("stall");

        // Overflow: 16 beats of 0xFF without last
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) beat(8'hFF, 1'b0, i % 2);
        chk("ovf_error", {31'd0, load_error}, 32'd1);
        chk("ovf_hold", {31'd0, cpu_hold}, 32'd1);
        chk("ovf_ready", {31'd0, load_ready}, 32'd0);
        chk("ovf_checksum", {24'd0, checksum}, 32'hF0);
        load_valid = 1'b1; load_data = 8'hFF;
        tick();
        load_valid = 1'b0;
        chk("ovf17_checksum", {24'd0, checksum}, 32'hF0);
        chk("ovf17_error_sticky", {31'd0, load_error}, 32'd1);
        set_em(8'hFF);
        check_mem("ovf");

        // Reset in the middle of a load
        pulse_start(1'b0);
        chk("restart_err_clr", {31'd0, load_error}, 32'd0);
        beat(8'h11, 1'b0, 0);
        beat(8'h22, 1'b0, 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_cs", {24'd0, checksum}, 32'h00);
        load_valid = 1'b1; load_data = 8'h33; load_last = 1'b1;
        tick(); tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("midrst_post_cs", {24'd0, checksum}, 32'h00);
        set_em(8'h00);
        check_mem("midrst");

        repeat (3) tick();
        chk("done_events_pending", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/k2_program_loader.md
Name: k2_program_loader

Overview:
- Writable 16-entry instruction store that sits directly upstream of the K2 processor.
- Replaces the fixed program ROM and drives the processor's instruction_data from its ProgramAddress.
- Programs are loaded as a valid/ready byte stream. The processor is held in reset until a complete program is present.
- A running checksum and an error flag let the testbench or host confirm that a load completed intact.

Parameters:
- ADDR_BITS, 4, program address width; depth = 2**ADDR_BITS.
- DATA_BITS, 8, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1).
- load_start  input  1  one-cycle request to begin a new program load.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  DATA_BITS  instruction byte to store.
- load_last  input  1  qualifies the final beat of the program.
- load_ready  output  1  loader accepts a beat this cycle.
- load_done  output  1  one-cycle pulse: program complete, processor released.
- load_error  output  1  sticky overflow flag.
- checksum  output  DATA_BITS  sum of all accepted bytes, mod 2**DATA_BITS.
- cpu_hold  output  1  1 = processor must be held in reset. The wrapper ties this into the processor reset.
- ProgramAddress  input  ADDR_BITS  fetch address from the processor.
- instruction_data  output  DATA_BITS  instruction at ProgramAddress.

Behaviour:
- States: EMPTY, LOAD, RUN. All state and outputs are registered except the fetch read.
- Reset (rst_n=1 at a clock edge):
  - state goes to EMPTY; all memory entries are cleared to 0.
  - wr_ptr=0, checksum=0, load_error=0, load_done=0.
  - Reset overrides everything, including a load in progress.
- Output decode from state:
  - cpu_hold = (state != RUN).
  - load_ready = (state == LOAD).
- Beat: load_valid & load_ready at a rising edge.
- EMPTY:
  - load_start moves to LOAD.
  - load_valid is ignored.
- LOAD entry, from EMPTY or RUN on load_start:
  - every memory entry is zeroed.
  - wr_ptr=0, checksum=0, load_error=0.
- LOAD beat:
  - mem[wr_ptr] <= load_data; checksum <= checksum + load_data (wraps); wr_ptr increments.
- Beat with load_last=1:
  - next state is RUN; load_done=1 for exactly the following cycle.
  - cpu_hold falls on the same edge.
- Beat at wr_ptr = depth-1 with load_last=0 (overflow):
  - the byte is written and added to the checksum.
  - next state is EMPTY; load_error=1 and stays set until the next load_start.
- load_start while already in LOAD: ignored; the load continues.
- load_valid=0 in LOAD: no state change; the stall length is unbounded.
- RUN:
  - load_start returns to LOAD. cpu_hold rises on that edge, so the processor is reset while reloading.
  - A beat presented in the same cycle as load_start is not accepted (load_ready=0 that cycle).
- Fetch: instruction_data = mem[ProgramAddress] combinationally, in every state.
  - A read of the address being written in the same cycle returns the old value.
  - The new value is visible after the edge.
- The last-beat and zero-fill rules above support programs shorter than depth: unwritten entries read 0.

Test Plan:
- Reset: rst_n=1 for 2 cycles → cpu_hold=1, load_ready=0, checksum=0x00, load_error=0, and instruction_data=0x00 for all 16 ProgramAddress values.
- Short load: load_start, then beats 0x12, 0x34, 0x56 with last on the 3rd → mem[0..2]=0x12/0x34/0x56 and mem[3..15]=0x00; checksum=0x9C; load_done high for exactly one cycle; cpu_hold=0 from the edge that accepts the last beat.
- Backpressure/stall: insert load_valid=0 gaps of 0–5 cycles between beats → contents and checksum are identical to the ungapped case; no extra load_done pulses.
- Overflow: 17 beats of 0xFF, none with last → load_error=1 after the 16th beat; state EMPTY; cpu_hold=1; checksum=0xF0; the 17th beat is not accepted (load_ready=0).
- Reload from RUN: after the short load, pulse load_start → cpu_hold=1 on the next edge and all entries read 0x00. A new 1-byte program 0xA5 with last → mem[0]=0xA5, checksum=0xA5, RUN again.
- Reset mid-load: assert rst_n after 2 of 4 beats → EMPTY, all entries 0x00, checksum=0x00, load_done never pulses.
